// File: rtl/opti_sample_feeder.sv
// Sample pacing stage in front of a single biquad section: FIFO buffering
// plus a one-outstanding-sample handshake with a guard gap after each result.
module opti_sample_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP_MIN = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [23:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [23:0]            sos_data,
  output logic                   sos_valid,
  input  logic                   sos_done,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_stray
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GAP_MIN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MIN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          stray_hit;

  assign s_ready    = (count != FULL_LVL);
  assign push       = s_valid && s_ready;
  assign fill_level = count;
  assign sos_valid  = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign stray_hit  = sos_done && (state != WAIT_DONE);

  // Storage array; not reset, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue register: loaded with the FIFO head on every pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sos_data <= '0;
    end else if (pop) begin
      sos_data <= mem[rd_ptr];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, pop and timeout decisions.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sos_done) begin
          state_nxt = GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt   = GAP;
          timeout_hit = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (count != '0) begin
            state_nxt = ISSUE;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Both counters sit at zero outside their state, so they start cleared on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP)       ? gap_cnt + 1'b1 : '0;
      tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
      if (stray_hit) begin
        err_stray <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_opti_sample_feeder.sv
// Self-checking bench for opti_sample_feeder: directed scenarios with literal
// expectations plus randomized traffic against a timestamp-based model.
module tb_opti_sample_feeder;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned GAP_MIN = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] sos_data;
  logic        sos_valid;
  logic        sos_done;
  logic [3:0]  fill_level;
  logic        busy;
  logic        err_timeout;
  logic        err_stray;

  logic dir_done;
  logic rnd_done;
  logic resp_done;
  assign sos_done = dir_done | rnd_done | resp_done;

  opti_sample_feeder #(
    .DEPTH   (DEPTH),
    .GAP_MIN (GAP_MIN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .sos_data    (sos_data),
    .sos_valid   (sos_valid),
    .sos_done    (sos_done),
    .fill_level  (fill_level),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_stray   (err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered samples plus timestamps (edge numbers)
  // of the outstanding issue and of the earliest edge allowed to issue again.
  int unsigned n_edge     = 0;
  logic [23:0] mq[$];
  bit          outst      = 0;
  int unsigned iss_edge   = 0;
  int unsigned ready_edge = 0;
  logic [23:0] m_data     = '0;
  bit          m_valid    = 0;
  bit          m_tmo      = 0;
  bit          m_stray    = 0;
  bit          m_push;
  bit          m_pop;

  always @(posedge clk) begin
    n_edge++;
    if (rst) begin
      mq.delete();
      outst      = 0;
      ready_edge = 0;
      m_data     = '0;
      m_valid    = 0;
      m_tmo      = 0;
      m_stray    = 0;
    end else begin
      m_push = s_valid && (mq.size() != DEPTH);
      m_pop  = !outst && (mq.size() > 0) && (n_edge >= ready_edge);
      if (outst && (n_edge > iss_edge + 1)) begin
        if (sos_done) begin
          outst      = 0;
          ready_edge = n_edge + GAP_MIN;
        end else if (n_edge - iss_edge == TIMEOUT + 1) begin
          outst      = 0;
          ready_edge = n_edge + GAP_MIN;
          m_tmo      = 1;
        end
      end else if (sos_done) begin
        m_stray = 1;
      end
      m_valid = m_pop;
      if (m_pop) begin
        m_data   = mq.pop_front();
        outst    = 1;
        iss_edge = n_edge;
      end
      if (m_push) begin
        mq.push_back(s_data);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("s_ready",     32'(s_ready),     32'(mq.size() != DEPTH));
    check("fill_level",  32'(fill_level),  32'(mq.size()));
    check("sos_valid",   32'(sos_valid),   32'(m_valid));
    check("sos_data",    32'(sos_data),    32'(m_data));
    check("busy",        32'(busy),        32'(outst || (n_edge < ready_edge)));
    check("err_timeout", 32'(err_timeout), 32'(m_tmo));
    check("err_stray",   32'(err_stray),   32'(m_stray));
  end

  // Section responder: answers each issue after a chosen latency.
  logic        resp_en   = 0;
  logic        resp_rand = 0;
  int unsigned resp_lat  = 5;
  int unsigned resp_cnt  = 0;
  int unsigned resp_r;

  always @(negedge clk) begin
    resp_done = 1'b0;
    if (rst || !resp_en) begin
      resp_cnt = 0;
    end else if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end else if (sos_valid) begin
      if (resp_rand) begin
        resp_r   = $urandom_range(15);
        resp_cnt = (resp_r == 0) ? 0 : (resp_r == 1) ? 70 : $urandom_range(8, 1);
      end else begin
        resp_cnt = resp_lat;
      end
    end
  end

  // Issue log for ordering and "no issue" checks.
  logic [23:0] issued[$];
  int          valid_cnt = 0;
  bit          saw_full  = 0;

  always @(negedge clk) begin
    if (sos_valid) begin
      issued.push_back(sos_data);
      valid_cnt++;
    end
    if (fill_level == 4'd8 && !s_ready) saw_full = 1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_fill",   32'(fill_level),  32'd0);
    check("rst_ready",  32'(s_ready),     32'd1);
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_valid",  32'(sos_valid),   32'd0);
    check("rst_data",   32'(sos_data),    32'd0);
    check("rst_tmo",    32'(err_timeout), 32'd0);
    check("rst_stray",  32'(err_stray),   32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  int guard;

  initial begin
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    dir_done = 1'b0;
    rnd_done = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    check("init_fill",  32'(fill_level), 32'd0);
    check("init_ready", 32'(s_ready),    32'd1);
    check("init_busy",  32'(busy),       32'd0);

    // Single sample: issue two cycles after the push, result three cycles later.
    s_valid = 1'b1;
    s_data  = 24'h123456;
    step();
    s_valid = 1'b0;
    check("single_no_early_valid", 32'(sos_valid), 32'd0);
    check("single_fill1",          32'(fill_level), 32'd1);
    step();
    check("single_valid",  32'(sos_valid), 32'd1);
    check("single_data",   32'(sos_data),  32'h123456);
    check("single_fill0",  32'(fill_level), 32'd0);
    step();
    check("single_pulse_once", 32'(sos_valid), 32'd0);
    step();
    dir_done = 1'b1;
    step();
    dir_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("gap_busy", 32'(busy), 32'd1);
      step();
    end
    check("gap_end_idle", 32'(busy), 32'd0);
    check("single_no_stray", 32'(err_stray), 32'd0);

    // Stray result in IDLE.
    dir_done = 1'b1;
    step();
    dir_done = 1'b0;
    check("stray_flag", 32'(err_stray), 32'd1);
    check("stray_idle", 32'(busy),      32'd0);
    step();
    check("stray_sticky", 32'(err_stray), 32'd1);

    // Reset with one outstanding and five queued samples.
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 24'h100 + 24'(i);
      step();
    end
    s_valid = 1'b0;
    check("queued5_fill", 32'(fill_level), 32'd5);
    check("queued5_busy", 32'(busy),       32'd1);
    do_reset();
    valid_cnt = 0;
    repeat (20) step();
    check("post_rst_no_issue", 32'(valid_cnt), 32'd0);

    // Timeout: no result ever returned; second sample follows after the gap.
    s_valid = 1'b1;
    s_data  = 24'hABCDEF;
    step();
    s_data = 24'h000002;
    step();
    s_valid = 1'b0;
    check("tmo_issue_data", 32'(sos_data),   32'hABCDEF);
    check("tmo_fill_swap",  32'(fill_level), 32'd1);
    repeat (64) step();
    check("tmo_not_yet", 32'(err_timeout), 32'd0);
    step();
    check("tmo_flag", 32'(err_timeout), 32'd1);
    check("tmo_busy", 32'(busy),        32'd1);
    repeat (3) step();
    check("tmo_gap_no_issue", 32'(sos_valid), 32'd0);
    step();
    check("tmo_next_valid", 32'(sos_valid), 32'd1);
    check("tmo_next_data",  32'(sos_data),  32'h000002);
    do_reset();

    // Burst of ten samples against a fixed-latency section.
    resp_en   = 1'b1;
    resp_rand = 1'b0;
    resp_lat  = 5;
    issued.delete();
    saw_full  = 0;
    for (int i = 1; i <= 10; i++) begin
      s_valid = 1'b1;
      s_data  = 24'(i);
      guard   = 0;
      while (!s_ready && guard < 200) begin
        step();
        guard++;
      end
      step();
    end
    s_valid = 1'b0;
    guard = 0;
    while ((issued.size() < 10 || busy) && guard < 400) begin
      step();
      guard++;
    end
    check("burst_count", 32'(issued.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("burst_order", 32'(issued[i]), 32'(i + 1));
    end
    check("burst_saw_full", 32'(saw_full), 32'd1);
    check("burst_no_tmo",   32'(err_timeout), 32'd0);

    // Randomized traffic, results, stray pulses and mid-run resets.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      resp_en   = 1'b1;
      resp_rand = 1'b1;
      for (int c = 0; c < 500; c++) begin
        s_valid  = ($urandom_range(99) < 32'(20 + r * 15));
        s_data   = 24'($urandom);
        rnd_done = ($urandom_range(49) == 0);
        if ((r % 2 == 1) && (c == 250)) begin
          s_valid  = 1'b0;
          rnd_done = 1'b0;
          do_reset();
        end
        step();
      end
    end
    s_valid  = 1'b0;
    rnd_done = 1'b0;
    resp_en  = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
